// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage control FSM (IDLE / FETCH / WAIT_MEM / DRAIN).
// Drives the PC and fetch/decode pipe enables, the decode and execute
// flushes, and the instruction-memory request.
// Optional feature macro: FETCH_CTRL_PERF_EN. When defined, it adds a 16-bit
// saturating stall counter on stallCycles. When undefined, stallCycles is
// tied to 0 and no counter register exists.
// Reset (rst) is asynchronous and active-low. The state register is cleared
// directly, so every combinational output takes its IDLE value immediately.
module fetch_ctrl (
  input  logic        clock,
  input  logic        rst,
  input  logic        imemReady,
  input  logic        ldUseHazard,
  input  logic        pcWrPendingD,
  input  logic        branchTakenE,
  input  logic        pcSrcW,
  output logic        imemReq,
  output logic        pcEnable,
  output logic        pipeEnable,
  output logic        flushD,
  output logic        flushE,
  output logic [2:0]  state,
  output logic [15:0] stallCycles
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_MEM = 3'd2,
    S_DRAIN    = 3'd3
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_drain_cnt;
  logic [1:0] w_drain_cnt_nxt;
  logic       w_drain_done;

  // The drain ends when the R15 write retires. It also ends when the count
  // runs out, which covers an R15 write whose condition failed.
  assign w_drain_done = pcSrcW || (r_drain_cnt == 2'd0);

  // State register and drain counter.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= 2'd0;
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  // Next-state and drain-count logic.
  always_comb begin
    w_next_state    = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    case (r_state)
      S_IDLE: begin
        w_next_state = S_FETCH;
      end
      S_FETCH: begin
        if (branchTakenE || ldUseHazard) begin
          w_next_state = S_FETCH;
        end else if (pcWrPendingD) begin
          w_next_state    = S_DRAIN;
          w_drain_cnt_nxt = 2'd3;
        end else if (!imemReady) begin
          w_next_state = S_WAIT_MEM;
        end
      end
      S_WAIT_MEM: begin
        if (branchTakenE || imemReady) w_next_state = S_FETCH;
      end
      S_DRAIN: begin
        // Count down without wrapping. Clear the count on exit so that no
        // stale value survives into the next drain.
        if (w_drain_done) begin
          w_next_state    = S_FETCH;
          w_drain_cnt_nxt = 2'd0;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt - 2'd1;
        end
      end
      default: begin
        w_next_state    = S_IDLE;
        w_drain_cnt_nxt = 2'd0;
      end
    endcase
  end

  // Output decode. The outputs depend only on the current state and inputs.
  always_comb begin
    imemReq    = 1'b0;
    pcEnable   = 1'b0;
    pipeEnable = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    case (r_state)
      S_IDLE: begin
        flushD = 1'b1;
      end
      S_FETCH: begin
        imemReq = 1'b1;
        if (branchTakenE) begin
          pcEnable   = 1'b1;
          pipeEnable = 1'b1;
          flushD     = 1'b1;
          flushE     = 1'b1;
        end else if (ldUseHazard) begin
          flushE = 1'b1;
        end else if (pcWrPendingD) begin
          pipeEnable = 1'b1;
          flushD     = 1'b1;
        end else if (imemReady) begin
          pcEnable   = 1'b1;
          pipeEnable = 1'b1;
        end
      end
      S_WAIT_MEM: begin
        imemReq = 1'b1;
        if (branchTakenE) begin
          pcEnable   = 1'b1;
          pipeEnable = 1'b1;
          flushD     = 1'b1;
          flushE     = 1'b1;
        end else if (imemReady) begin
          pcEnable   = 1'b1;
          pipeEnable = 1'b1;
        end
      end
      S_DRAIN: begin
        // branchTakenE is ignored here: the older R15 write governs.
        pipeEnable = 1'b1;
        flushD     = 1'b1;
        pcEnable   = w_drain_done;
      end
      default: begin
        flushD = 1'b1;
      end
    endcase
  end

  assign state = r_state;

`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] r_stall_cnt;

  // Count cycles outside IDLE in which the PC is held, saturating at 0xFFFF.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= 16'd0;
    end else if (!pcEnable && (r_state != S_IDLE) && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stallCycles = r_stall_cnt;
`else
  assign stallCycles = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed-vector bench for fetch_ctrl.
// A behavioural model written from the mode rules is compared against every
// output on each falling clock edge. Hand-computed literal checks pin key
// points of each scenario.
// The input vector encoding is {imemReady, ldUseHazard, pcWrPendingD,
// branchTakenE, pcSrcW}.
module tb_fetch_ctrl;

  logic        clock;
  logic        rst;
  logic        imemReady;
  logic        ldUseHazard;
  logic        pcWrPendingD;
  logic        branchTakenE;
  logic        pcSrcW;
  logic        imemReq;
  logic        pcEnable;
  logic        pipeEnable;
  logic        flushD;
  logic        flushE;
  logic [2:0]  state;
  logic [15:0] stallCycles;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_ctrl dut (
    .clock        (clock),
    .rst          (rst),
    .imemReady    (imemReady),
    .ldUseHazard  (ldUseHazard),
    .pcWrPendingD (pcWrPendingD),
    .branchTakenE (branchTakenE),
    .pcSrcW       (pcSrcW),
    .imemReq      (imemReq),
    .pcEnable     (pcEnable),
    .pipeEnable   (pipeEnable),
    .flushD       (flushD),
    .flushE       (flushE),
    .state        (state),
    .stallCycles  (stallCycles)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  // Modes: 0 idle, 1 fetch, 2 waiting on memory, 3 draining an R15 write.
  // m_age is the number of cycles already spent draining. The drain ends
  // after its fourth cycle (age 3) unless pcSrcW ends it earlier.
  int          m_mode  = 0;
  int          m_age   = 0;
  logic [15:0] m_stall = 16'd0;

  // Returns {imemReq, pcEnable, pipeEnable, flushD, flushE}.
  function automatic logic [4:0] exp_out(int mode, int age, logic [4:0] v);
    logic rdy, ld, pcw, br, src;
    {rdy, ld, pcw, br, src} = v;
    case (mode)
      1: begin
        if (br)        return 5'b11111;
        else if (ld)   return 5'b10001;
        else if (pcw)  return 5'b10110;
        else if (!rdy) return 5'b10000;
        else           return 5'b11100;
      end
      2: begin
        if (br)       return 5'b11111;
        else if (rdy) return 5'b11100;
        else          return 5'b10000;
      end
      3:       return (src || age == 3) ? 5'b01110 : 5'b00110;
      default: return 5'b00010;
    endcase
  endfunction

  function automatic int next_mode(int mode, int age, logic [4:0] v);
    logic rdy, ld, pcw, br, src;
    {rdy, ld, pcw, br, src} = v;
    case (mode)
      0: return 1;
      1: begin
        if (br || ld) return 1;
        else if (pcw) return 3;
        else if (!rdy) return 2;
        else return 1;
      end
      2:       return (br || rdy) ? 1 : 2;
      3:       return (src || age == 3) ? 1 : 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [4:0] cur_in();
    return {imemReady, ldUseHazard, pcWrPendingD, branchTakenE, pcSrcW};
  endfunction

  // Advance the model on each rising edge; clear it on reset.
  always @(posedge clock or negedge rst) begin
    if (!rst) begin
      m_mode  <= 0;
      m_age   <= 0;
      m_stall <= 16'd0;
    end else begin
      if (!exp_out(m_mode, m_age, cur_in())[3] && m_mode != 0 && m_stall != 16'hFFFF)
        m_stall <= m_stall + 16'd1;
      m_age  <= (m_mode == 3 && next_mode(m_mode, m_age, cur_in()) == 3) ? m_age + 1 : 0;
      m_mode <= next_mode(m_mode, m_age, cur_in());
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clock) begin
    logic [15:0] exp_stall;
`ifdef FETCH_CTRL_PERF_EN
    exp_stall = m_stall;
`else
    exp_stall = 16'd0;
`endif
    chk("cyc_outs", {11'd0, imemReq, pcEnable, pipeEnable, flushD, flushE},
        {11'd0, exp_out(m_mode, m_age, cur_in())});
    chk("cyc_state", {13'd0, state}, 16'(m_mode));
    chk("cyc_stall", stallCycles, exp_stall);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(logic [4:0] v);
    {imemReady, ldUseHazard, pcWrPendingD, branchTakenE, pcSrcW} = v;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(logic [4:0] v);
    drive(v);
    tick();
  endtask

  // Priority and mode-transition mix. Each entry is applied for one cycle.
  localparam int NTAB = 12;
  logic [4:0] tab [NTAB] = '{5'b11100, 5'b01000, 5'b00100, 5'b00000, 5'b00000,
                             5'b00001, 5'b10010, 5'b00000, 5'b00000, 5'b10000,
                             5'b00100, 5'b10000};

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] stall_exp;
`ifdef FETCH_CTRL_PERF_EN
    stall_exp = 16'd3;
`else
    stall_exp = 16'd0;
`endif
    rst = 1'b0;
    drive(5'b10000);
    #22;
    // Outputs take their IDLE values while reset is held.
    chk("rst_state", {13'd0, state}, 16'd0);
    chk("rst_flushD", {15'd0, flushD}, 16'd1);
    chk("rst_pcEnable", {15'd0, pcEnable}, 16'd0);
    chk("rst_stall", stallCycles, 16'd0);
    rst = 1'b1;
    #1;
    chk("rel_idle", {13'd0, state}, 16'd0);
    tick();
    chk("rel_fetch", {13'd0, state}, 16'd1);
    chk("rel_pcEnable", {15'd0, pcEnable}, 16'd1);

    // Memory not ready for three cycles, then ready.
    step(5'b00000);
    chk("wm_enter", {13'd0, state}, 16'd2);
    step(5'b00000);
    drive(5'b00000);
    #1;
    chk("wm_pcEnable", {15'd0, pcEnable}, 16'd0);
    tick();
    drive(5'b10000);
    #1;
    chk("wm_ready_pcEnable", {15'd0, pcEnable}, 16'd1);
    tick();
    chk("wm_exit", {13'd0, state}, 16'd1);
    chk("wm_stall", stallCycles, stall_exp);

    // R15 write in decode; the write retires two cycles later.
    step(5'b10100);
    chk("dr_enter", {13'd0, state}, 16'd3);
    step(5'b10000);
    drive(5'b10001);
    #1;
    chk("dr_src_pcEnable", {15'd0, pcEnable}, 16'd1);
    chk("dr_src_flushD", {15'd0, flushD}, 16'd1);
    tick();
    chk("dr_src_exit", {13'd0, state}, 16'd1);

    // R15 write with a failed condition: the drain runs out on its own.
    step(5'b10100);
    for (int i = 0; i < 4; i++) begin
      drive(5'b10000);
      #1;
      chk("drf_pcEnable", {15'd0, pcEnable}, (i == 3) ? 16'd1 : 16'd0);
      tick();
      chk("drf_state", {13'd0, state}, (i == 3) ? 16'd1 : 16'd3);
    end

    // A branch beats a load-use hazard in FETCH and also ends a memory wait.
    drive(5'b11010);
    #1;
    chk("br_flushD", {15'd0, flushD}, 16'd1);
    chk("br_flushE", {15'd0, flushE}, 16'd1);
    chk("br_pcEnable", {15'd0, pcEnable}, 16'd1);
    tick();
    chk("br_stay", {13'd0, state}, 16'd1);
    step(5'b00000);
    step(5'b01010);
    chk("br_wm_exit", {13'd0, state}, 16'd1);

    // A branch during a drain is ignored.
    step(5'b10100);
    drive(5'b10010);
    #1;
    chk("drbr_flushE", {15'd0, flushE}, 16'd0);
    chk("drbr_pcEnable", {15'd0, pcEnable}, 16'd0);
    tick();
    chk("drbr_state", {13'd0, state}, 16'd3);

    // Reset in mid-drain takes effect without a clock edge.
    drive(5'b10000);
    #2;
    rst = 1'b0;
    #1;
    chk("ard_state", {13'd0, state}, 16'd0);
    chk("ard_flushD", {15'd0, flushD}, 16'd1);
    chk("ard_pcEnable", {15'd0, pcEnable}, 16'd0);
    chk("ard_pipe_flushE", {14'd0, pipeEnable, flushE}, 16'd0);
    chk("ard_stall", stallCycles, 16'd0);
    #3;
    rst = 1'b1;
    #1;
    chk("ard_rel_idle", {13'd0, state}, 16'd0);
    tick();
    chk("ard_rel_fetch", {13'd0, state}, 16'd1);

    // Reset in the middle of a memory wait.
    step(5'b00000);
    chk("arw_wait", {13'd0, state}, 16'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("arw_req", {15'd0, imemReq}, 16'd0);
    chk("arw_pipe", {15'd0, pipeEnable}, 16'd0);
    chk("arw_state", {13'd0, state}, 16'd0);
    #2;
    rst = 1'b1;
    drive(5'b10000);
    tick();
    chk("arw_rel_fetch", {13'd0, state}, 16'd1);

    // Priority/transition mix.
    for (int i = 0; i < NTAB; i++) step(tab[i]);
    step(5'b10000);
    step(5'b10000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port imemReady, input, 1, instruction memory has valid data for the current PC this cycle.
REQ-004 SHALL have port ldUseHazard, input, 1, decode instruction depends on a load currently in execute.
REQ-005 SHALL have port pcWrPendingD, input, 1, decode instruction writes R15.
REQ-006 SHALL have port branchTakenE, input, 1, branch resolved taken in execute.
REQ-007 SHALL have port pcSrcW, input, 1, R15 write is retiring in writeback.
REQ-008 SHALL have port imemReq, output, 1, fetch request to instruction memory.
REQ-009 SHALL have port pcEnable, output, 1, PC register load enable.
REQ-010 SHALL have port pipeEnable, output, 1, fetch/decode pipe register enable.
REQ-011 SHALL have port flushD, output, 1, clear fetch/decode pipe register.
REQ-012 SHALL have port flushE, output, 1, clear decode/execute pipe register.
REQ-013 SHALL have port state, output, 3, current FSM state encoding.
REQ-014 SHALL have port stallCycles, output, 16, stall performance counter (see Configuration).

Function
REQ-015 SHALL implement states IDLE=0, FETCH=1, WAIT_MEM=2, DRAIN=3; all outputs are combinational from state and inputs, with no added latency.
REQ-016 IDLE: imemReq=0, pcEnable=0, pipeEnable=0, flushD=1, flushE=0; next state FETCH unconditionally.
REQ-017 FETCH priority, highest first: branchTakenE > ldUseHazard > pcWrPendingD > !imemReady > normal.
REQ-018 FETCH+branchTakenE: pcEnable=1, pipeEnable=1, flushD=1, flushE=1; stay FETCH.
REQ-019 FETCH+ldUseHazard: pcEnable=0, pipeEnable=0, flushE=1, flushD=0; stay FETCH.
REQ-020 FETCH+pcWrPendingD: pcEnable=0, pipeEnable=1, flushD=1; load drainCnt=3; go DRAIN.
REQ-021 FETCH+!imemReady: pcEnable=0, pipeEnable=0, flushD=0; go WAIT_MEM.
REQ-022 FETCH normal: pcEnable=1, pipeEnable=1, no flush.
REQ-023 imemReq SHALL be 1 in FETCH and WAIT_MEM, and 0 in IDLE and DRAIN.
REQ-024 WAIT_MEM: pcEnable=0, pipeEnable=0 until imemReady=1; on that cycle pcEnable=1, pipeEnable=1, next FETCH.
REQ-025 WAIT_MEM+branchTakenE SHALL override the wait: pcEnable=1, flushD=1, flushE=1, next FETCH.
REQ-026 DRAIN: pcEnable=0, pipeEnable=1, flushD=1 every cycle; drainCnt (2-bit) decrements each cycle.
REQ-027 DRAIN+pcSrcW: pcEnable=1, next FETCH, regardless of drainCnt.
REQ-028 DRAIN with drainCnt==0 and !pcSrcW (condition-failed R15 write): pcEnable=1, next FETCH; drainCnt SHALL NOT wrap below 0.
REQ-029 DRAIN+branchTakenE SHALL be ignored; the older R15 write governs.

Reset
REQ-030 rst=0 SHALL immediately force state=IDLE, drainCnt=0, stallCycles=0, independent of clock.
REQ-031 While rst=0, outputs SHALL equal the IDLE values; the first FETCH cycle SHALL be the second rising edge after rst rises.
REQ-032 Reset asserted during WAIT_MEM or DRAIN SHALL abandon the operation with no residual flush or enable.

Configuration
REQ-033 With FETCH_CTRL_PERF_EN defined, stallCycles SHALL increment by 1 on every cycle with pcEnable=0 and state!=IDLE, saturating at 0xFFFF.
REQ-034 Without FETCH_CTRL_PERF_EN, stallCycles SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-035 Release rst, imemReady=1, all other inputs 0 -> state IDLE then FETCH; pcEnable=1 from the 2nd edge onward.
REQ-036 In FETCH, imemReady=0 for 3 cycles then 1 -> WAIT_MEM with pcEnable=0 for 3 cycles, then pcEnable=1 and return to FETCH; stallCycles=3 with PERF_EN.
REQ-037 pcWrPendingD=1 for 1 cycle, pcSrcW=1 two cycles later -> DRAIN with flushD=1 and pcEnable=0 for 2 cycles, pcEnable=1 on the pcSrcW cycle, then FETCH.
REQ-038 pcWrPendingD=1 with no pcSrcW -> DRAIN lasts 4 cycles (drainCnt 3,2,1,0), exits on drainCnt==0 with pcEnable=1.
REQ-039 branchTakenE=1 together with ldUseHazard=1 in FETCH -> flushD=1, flushE=1, pcEnable=1 (branch wins); repeat in WAIT_MEM -> next state FETCH.
REQ-040 Assert rst=0 mid-DRAIN -> state=0, flushD=1, pcEnable=0 within the same cycle, with no clock edge required.
